// File: rtl/vram_arbiter.sv
// vram_arbiter: arbitrates one shared single-port frame memory between a
// display fetcher (highest priority), a waveform writer and a clear engine
// that sweeps every address once. All memory-side outputs are registered.
// A display fetch returns its word a fixed three cycles after it is granted.
module vram_arbiter #(
    parameter int          DEPTH       = 16384,
    parameter logic [15:0] CLEAR_VALUE = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vga_req,
    input  logic [13:0] vga_addr,
    output logic [15:0] vga_data,
    output logic        vga_valid,
    input  logic        wr_req,
    input  logic [13:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic        wr_ack,
    input  logic        clr_start,
    output logic        clr_busy,
    output logic [13:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata
);

    localparam logic [13:0] LAST_ADDR = 14'(DEPTH - 1);

    typedef enum logic {
        C_IDLE,
        C_RUN
    } clr_state_e;

    typedef enum logic [1:0] {
        G_IDLE,
        G_VGA,
        G_WR,
        G_CLR
    } grant_e;

    grant_e      grant;
    clr_state_e  clr_state_q, clr_state_d;
    logic [13:0] clr_cnt_q, clr_cnt_d;
    logic [13:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;
    logic        wr_ack_q, wr_ack_d;
    logic        rd_pend1_q, rd_pend2_q;
    logic        vga_valid_q;
    logic [15:0] vga_data_q;

    // Fixed-priority grant: display, then a writer not acked this cycle, then clear.
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = G_IDLE;
        if (vga_req) begin
            grant = G_VGA;
        end else if (wr_req && !wr_ack_q) begin
            grant = G_WR;
        end else if (clr_state_q == C_RUN) begin
            grant = G_CLR;
        end
    end

    // Memory command for next cycle; an idle cycle keeps address/data and drops the strobe.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        wr_ack_d    = 1'b0;
        unique case (grant)
            G_VGA: begin
                mem_addr_d = vga_addr;
            end
            G_WR: begin
                mem_addr_d  = wr_addr;
                mem_wdata_d = wr_data;
                mem_we_d    = 1'b1;
                wr_ack_d    = 1'b1;
            end
            G_CLR: begin
                mem_addr_d  = clr_cnt_q;
                mem_wdata_d = CLEAR_VALUE;
                mem_we_d    = 1'b1;
            end
            default: ;
        endcase
    end

    // Clear engine: start restarts nothing while running; counter only moves on a clear grant.
    always_comb begin
        clr_state_d = clr_state_q;
        clr_cnt_d   = clr_cnt_q;
        unique case (clr_state_q)
            C_IDLE: begin
                if (clr_start) begin
                    clr_state_d = C_RUN;
                    clr_cnt_d   = '0;
                end
            end
            C_RUN: begin
                if (grant == G_CLR) begin
                    if (clr_cnt_q == LAST_ADDR) begin
                        clr_state_d = C_IDLE;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 14'd1;
                    end
                end
            end
            default: clr_state_d = C_IDLE;
        endcase
    end

    // State, memory command and display read pipeline registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: the read pipeline flags are reset along with everything else so a
    // fetch in flight at reset can never surface as a stale vga_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_state_q <= C_IDLE;
            clr_cnt_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            wr_ack_q    <= 1'b0;
            rd_pend1_q  <= 1'b0;
            rd_pend2_q  <= 1'b0;
            vga_valid_q <= 1'b0;
            vga_data_q  <= '0;
        end else begin
            clr_state_q <= clr_state_d;
            clr_cnt_q   <= clr_cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            wr_ack_q    <= wr_ack_d;
            // Stage 1: address on the bus; stage 2: read data on mem_rdata.
            rd_pend1_q  <= (grant == G_VGA);
            rd_pend2_q  <= rd_pend1_q;
            vga_valid_q <= rd_pend2_q;
            if (rd_pend2_q) begin
                vga_data_q <= mem_rdata;
            end
        end
    end

    assign clr_busy  = (clr_state_q == C_RUN);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign wr_ack    = wr_ack_q;
    assign vga_valid = vga_valid_q;
    assign vga_data  = vga_data_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: a transaction-level model (priority rules, a shadow
// memory and a due-cycle queue of display fetches) checked against the DUT on
// every cycle, plus directed scenarios with literal expectations.
module tb_vram_arbiter;

    localparam int          DEPTH_TB = 16;
    localparam logic [15:0] CLR_V    = 16'h0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vga_req = 1'b0;
    logic [13:0] vga_addr = '0;
    logic [15:0] vga_data;
    logic        vga_valid;
    logic        wr_req = 1'b0;
    logic [13:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ack;
    logic        clr_start = 1'b0;
    logic        clr_busy;
    logic [13:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;

    always #5 clk = ~clk;

    vram_arbiter #(.DEPTH(DEPTH_TB), .CLEAR_VALUE(CLR_V)) dut (
        .clk(clk), .reset(reset),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data), .vga_valid(vga_valid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // Physical synchronous-read memory; unwritten words read back as their address.
    logic [15:0] phys_mem [16384];
    bit          phys_wr  [16384];
    always @(posedge clk) begin
        if (mem_we) begin
            phys_mem[mem_addr] <= mem_wdata;
            phys_wr[mem_addr]  <= 1'b1;
        end
        mem_rdata <= phys_wr[mem_addr] ? phys_mem[mem_addr] : {2'b00, mem_addr};
    end

    // ---------------- reference model ----------------
    int          cyc = 0;
    logic        e_valid = 1'b0, e_ack = 1'b0, e_busy = 1'b0, e_we = 1'b0;
    logic [15:0] e_data = '0, e_wdata = '0;
    logic [13:0] e_addr = '0;
    int          m_cnt = 0;
    int          rq_due[$];
    logic [15:0] rq_data[$];
    logic [15:0] ref_mem [16384];
    bit          ref_wr  [16384];

    function automatic logic [15:0] ref_read(input logic [13:0] a);
        return ref_wr[a] ? ref_mem[a] : {2'b00, a};
    endfunction

    initial begin : model
        logic ack_now, busy_now;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                e_valid = 1'b0; e_ack = 1'b0; e_busy = 1'b0; e_we = 1'b0;
                e_data = '0; e_wdata = '0; e_addr = '0; m_cnt = 0;
                rq_due.delete(); rq_data.delete();
            end else begin
                ack_now  = e_ack;
                busy_now = e_busy;
                e_ack = 1'b0;
                e_we  = 1'b0;
                if (vga_req) begin
                    rq_due.push_back(cyc + 3);
                    rq_data.push_back(ref_read(vga_addr));
                    e_addr = vga_addr;
                end else if (wr_req && !ack_now) begin
                    e_we = 1'b1; e_ack = 1'b1; e_addr = wr_addr; e_wdata = wr_data;
                    ref_mem[wr_addr] = wr_data; ref_wr[wr_addr] = 1'b1;
                end else if (busy_now) begin
                    e_we = 1'b1; e_addr = 14'(m_cnt); e_wdata = CLR_V;
                    ref_mem[14'(m_cnt)] = CLR_V; ref_wr[14'(m_cnt)] = 1'b1;
                    if (m_cnt == DEPTH_TB - 1) e_busy = 1'b0;
                    else m_cnt = m_cnt + 1;
                end
                if (clr_start && !busy_now) begin
                    e_busy = 1'b1;
                    m_cnt  = 0;
                end
                cyc = cyc + 1;
                e_valid = 1'b0;
                if (rq_due.size() > 0 && rq_due[0] == cyc) begin
                    e_valid = 1'b1;
                    e_data  = rq_data.pop_front();
                    void'(rq_due.pop_front());
                end
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("mdl vga_valid", 32'(vga_valid), 32'(e_valid));
        if (e_valid || reset) check("mdl vga_data", 32'(vga_data), 32'(e_data));
        check("mdl wr_ack",    32'(wr_ack),    32'(e_ack));
        check("mdl clr_busy",  32'(clr_busy),  32'(e_busy));
        check("mdl mem_we",    32'(mem_we),    32'(e_we));
        check("mdl mem_addr",  32'(mem_addr),  32'(e_addr));
        check("mdl mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    endtask

    // Event logs filled at each negedge.
    int          w_cyc[$];
    logic [13:0] w_addr[$];
    logic [15:0] w_data[$];
    int          v_cyc[$];
    logic [15:0] v_data[$];
    int          b_cyc[$];
    int          a_cyc[$];

    task automatic clear_logs();
        w_cyc.delete(); w_addr.delete(); w_data.delete();
        v_cyc.delete(); v_data.delete(); b_cyc.delete(); a_cyc.delete();
    endtask

    // Compare and log mid-cycle, then land just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        compare_model();
        if (mem_we) begin
            w_cyc.push_back(cyc); w_addr.push_back(mem_addr); w_data.push_back(mem_wdata);
        end
        if (vga_valid) begin
            v_cyc.push_back(cyc); v_data.push_back(vga_data);
        end
        if (clr_busy) b_cyc.push_back(cyc);
        if (wr_ack)   a_cyc.push_back(cyc);
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [13:0] a, input logic [15:0] d, output int ack_cyc);
        ack_cyc = -1;
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (wr_ack) begin
                ack_cyc = cyc;
                break;
            end
        end
        if (ack_cyc < 0) check("write ack timeout", 32'd0, 32'd1);
        wr_req = 1'b0;
    endtask

    task automatic vga_fetch(input logic [13:0] a, output logic [15:0] d, output int lat);
        int s;
        s = cyc; lat = -1; d = '0;
        vga_req = 1'b1; vga_addr = a;
        tick();
        vga_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (vga_valid) begin
                lat = cyc - s;
                d   = vga_data;
                break;
            end
            tick();
        end
        if (lat < 0) check("fetch valid timeout", 32'd0, 32'd1);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int s, ack_c, lat, n;
        logic [15:0] d;

        // Reset state.
        repeat (3) tick();
        check("reset mem_we",    32'(mem_we),    32'd0);
        check("reset mem_addr",  32'(mem_addr),  32'd0);
        check("reset vga_valid", 32'(vga_valid), 32'd0);
        check("reset clr_busy",  32'(clr_busy),  32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // Back-to-back fetches of 5..8 return three cycles later, one per cycle.
        clear_logs();
        s = cyc;
        for (int i = 0; i < 4; i++) begin
            vga_req = 1'b1; vga_addr = 14'(5 + i);
            tick();
        end
        vga_req = 1'b0;
        repeat (6) tick();
        check("burst valid count", 32'(v_data.size()), 32'd4);
        for (int k = 0; k < 4 && k < v_data.size(); k++) begin
            check("burst data",  32'(v_data[k]), 32'(5 + k));
            check("burst cycle", 32'(v_cyc[k]),  32'(s + 3 + k));
        end

        // Single write with no display traffic.
        s = cyc;
        do_write(14'h0100, 16'hBEEF, ack_c);
        check("write ack latency", 32'(ack_c), 32'(s + 1));
        check("write mem_we",    32'(mem_we),    32'd1);
        check("write mem_addr",  32'(mem_addr),  32'h0100);
        check("write mem_wdata", 32'(mem_wdata), 32'hBEEF);
        tick();
        check("write ack one cycle", 32'(wr_ack), 32'd0);

        // Writer starved by ten display cycles, acked once right after.
        clear_logs();
        s = cyc;
        wr_req = 1'b1; wr_addr = 14'h0200; wr_data = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            vga_req = 1'b1; vga_addr = 14'(20 + i);
            tick();
        end
        vga_req = 1'b0;
        ack_c = -1;
        for (int i = 0; i < 20; i++) begin
            if (wr_ack) begin
                ack_c = cyc;
                break;
            end
            tick();
        end
        wr_req = 1'b0;
        check("starved ack cycle", 32'(ack_c), 32'(s + 11));
        check("starved no writes", 32'(w_cyc.size()), 32'd0);
        repeat (5) tick();
        check("starved ack count",   32'(a_cyc.size()), 32'd1);
        check("starved write count", 32'(w_cyc.size()), 32'd1);

        // Full clear of 16 words with a second start ignored mid-clear.
        clear_logs();
        s = cyc;
        clr_start = 1'b1;
        tick();
        for (int i = 0; i < 24; i++) begin
            clr_start = (cyc == s + 6);
            tick();
        end
        clr_start = 1'b0;
        check("clear write count", 32'(w_cyc.size()), 32'd16);
        for (int k = 0; k < 16 && k < w_cyc.size(); k++) begin
            check("clear addr",  32'(w_addr[k]), 32'(k));
            check("clear data",  32'(w_data[k]), 32'h0);
            check("clear cycle", 32'(w_cyc[k]),  32'(s + 2 + k));
        end
        check("clear busy cycles", 32'(b_cyc.size()), 32'd16);
        if (b_cyc.size() == 16) begin
            check("clear busy first", 32'(b_cyc[0]),  32'(s + 1));
            check("clear busy last",  32'(b_cyc[15]), 32'(s + 16));
        end
        vga_fetch(14'd0, d, lat);
        check("cleared word 0",  32'(d), 32'h0);
        check("fetch latency",   32'(lat), 32'd3);
        vga_fetch(14'd15, d, lat);
        check("cleared word 15", 32'(d), 32'h0);
        vga_fetch(14'd16, d, lat);
        check("word 16 untouched", 32'(d), 32'h0010);

        // Writer and display interleaved with a running clear.
        clear_logs();
        s = cyc;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (5) tick();
        do_write(14'd3, 16'hAAAA, ack_c);
        check("mid-clear ack cycle", 32'(ack_c), 32'(s + 7));
        for (int i = 0; i < 2; i++) begin
            vga_req = 1'b1; vga_addr = 14'(100 + i);
            tick();
        end
        vga_req = 1'b0;
        n = 0;
        while (clr_busy && n < 60) begin
            tick();
            n++;
        end
        check("mid-clear finished", 32'(clr_busy), 32'd0);
        repeat (3) tick();
        n = 0;
        foreach (w_data[k]) if (w_data[k] == 16'h0) n++;
        check("mid-clear clear writes", 32'(n), 32'd16);
        vga_fetch(14'd3, d, lat);
        check("writer word kept", 32'(d), 32'hAAAA);
        vga_fetch(14'd2, d, lat);
        check("neighbour cleared", 32'(d), 32'h0);

        // Reset mid-clear (counter at 7) with a fetch in flight.
        s = cyc;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (7) tick();
        vga_req = 1'b1; vga_addr = 14'd50;
        tick();
        vga_req = 1'b0;
        check("pre-reset busy",     32'(clr_busy), 32'd1);
        check("pre-reset mem_addr", 32'(mem_addr), 32'd50);
        reset = 1'b1;
        #1;
        check("async reset vga_valid", 32'(vga_valid), 32'd0);
        check("async reset vga_data",  32'(vga_data),  32'd0);
        check("async reset wr_ack",    32'(wr_ack),    32'd0);
        check("async reset clr_busy",  32'(clr_busy),  32'd0);
        check("async reset mem_we",    32'(mem_we),    32'd0);
        check("async reset mem_addr",  32'(mem_addr),  32'd0);
        check("async reset mem_wdata", 32'(mem_wdata), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        clear_logs();
        repeat (12) tick();
        check("post-reset valids", 32'(v_cyc.size()), 32'd0);
        check("post-reset writes", 32'(w_cyc.size()), 32'd0);
        check("post-reset busy",   32'(b_cyc.size()), 32'd0);
        check("post-reset acks",   32'(a_cyc.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter DEPTH, default 16384; number of 16-bit words in the shared frame memory; the clear engine visits addresses 0..DEPTH-1.
REQ-002 Parameter CLEAR_VALUE, default 16'h0000; word written by the clear engine.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 vga_req  input  1  display fetch request, sampled each cycle.
REQ-006 vga_addr  input  14  display fetch word address.
REQ-007 vga_data  output  16  fetched word.
REQ-008 vga_valid  output  1  one-cycle pulse; vga_data holds the word for the matching request.
REQ-009 wr_req  input  1  waveform-writer write request; held with wr_addr/wr_data until wr_ack.
REQ-010 wr_addr  input  14  write word address.
REQ-011 wr_data  input  16  write word.
REQ-012 wr_ack  output  1  one-cycle pulse; write issued to memory.
REQ-013 clr_start  input  1  single-cycle pulse; starts a full-memory clear.
REQ-014 clr_busy  output  1  clear in progress.
REQ-015 mem_addr  output  14  shared memory address, registered.
REQ-016 mem_wdata  output  16  shared memory write data, registered.
REQ-017 mem_we  output  1  shared memory write enable, registered.
REQ-018 mem_rdata  input  16  synchronous-read data; valid the cycle after mem_addr is presented.

Function
REQ-019 Each cycle exactly one grant is chosen with fixed priority: VGA (vga_req=1), then writer (wr_req=1 and wr_ack=0), then clear engine (clr_busy=1), else idle.
REQ-020 Grant chosen in cycle N drives mem_addr/mem_wdata/mem_we in cycle N+1; idle grant drives mem_we=0 with mem_addr/mem_wdata holding their last value.
REQ-021 VGA grant: mem_we=0, mem_addr=vga_addr; vga_data registered from mem_rdata and vga_valid=1 in cycle N+3; fixed latency 3 cycles, fully pipelined, one fetch per cycle sustained.
REQ-022 Writer grant: mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1 in cycle N+1 only.
REQ-023 Writer is never granted in a cycle where wr_ack=1; a wr_req still high in the cycle after wr_ack is treated as a new request.
REQ-024 Writer waits without limit while vga_req=1; wr_ack never asserts without a corresponding memory write.
REQ-025 Clear engine states: C_IDLE, C_RUN. C_IDLE -> C_RUN on clr_start; clear counter loaded with 0; clr_busy=1 from the following cycle.
REQ-026 C_RUN: each clear grant writes CLEAR_VALUE to mem_addr=counter, counter increments; cycles without clear grant hold the counter.
REQ-027 Clear grant with counter=DEPTH-1 returns to C_IDLE; clr_busy=0 in the next cycle; counter does not wrap.
REQ-028 clr_start while clr_busy=1 is ignored; counter is not restarted.
REQ-029 Writer writes during C_RUN are issued normally; clear does not overwrite already-cleared addresses again.
REQ-030 Simultaneous vga_req, wr_req, clr_start: VGA granted, writer next free cycle, clear starts per REQ-025 and takes the first cycle with no higher-priority request.

Reset
REQ-031 While reset=1: vga_valid=0, wr_ack=0, clr_busy=0, mem_we=0, mem_addr=0, mem_wdata=0, vga_data=0, clear FSM in C_IDLE, counter=0, VGA read pipeline flushed.
REQ-032 Reset asserted mid-clear or with fetches in flight abandons them; no vga_valid or wr_ack pulse is produced for pre-reset requests after reset deasserts.

Verification
REQ-033 Bench: vga_req=1 for 4 cycles, addresses 5,6,7,8, memory model word=addr -> vga_valid pulses 3 cycles after each request with vga_data 5,6,7,8 back-to-back.
REQ-034 Bench: wr_req=1, wr_addr=0x0100, wr_data=0xBEEF, vga_req=0 -> next cycle mem_we=1, mem_addr=0x0100, mem_wdata=0xBEEF, wr_ack=1 for one cycle.
REQ-035 Bench: vga_req=1 for 10 cycles with wr_req=1 held -> no mem_we for 10 cycles; wr_ack exactly once, in the cycle after vga_req falls.
REQ-036 Bench: DEPTH=16, clr_start pulse, no other requests -> 16 consecutive writes of 0 to addresses 0..15; clr_busy high 16 cycles then low; second clr_start mid-clear ignored.
REQ-037 Bench: reset asserted when clear counter=7 with a VGA fetch in flight -> outputs at reset values immediately; after release clr_busy=0, no vga_valid, no writes.
